// File: rtl/c_enc_if.sv
// Handshake bundle for c_enc: count command in, registered unary-code beat out.
// Sized by W, so the count field is $clog2(W) bits wide.
interface c_enc_if #(
    parameter int W = 16
) ();
    localparam int CW = $clog2(W);

    logic          i_in_vld;
    logic [CW-1:0] i_in_n;
    logic          i_in_compliment;
    logic          i_in_ramp;
    logic          o_in_rdy;
    logic          o_out_vld;
    logic [W-1:0]  o_out_x;
    logic          o_out_compliment;
    logic          o_out_last;
    logic          o_out_err;
    logic          i_out_rdy;

    modport master (
        output i_in_vld, i_in_n, i_in_compliment, i_in_ramp, i_out_rdy,
        input  o_in_rdy, o_out_vld, o_out_x, o_out_compliment, o_out_last, o_out_err
    );

    modport slave (
        input  i_in_vld, i_in_n, i_in_compliment, i_in_ramp, i_out_rdy,
        output o_in_rdy, o_out_vld, o_out_x, o_out_compliment, o_out_last, o_out_err
    );
endinterface

// File: rtl/c_enc.sv
// Binary count to W-bit unary/thermometer code, optionally complemented; ramp mode under C_ENC_RAMP_EN.
// Latency: one cycle, accepted command appears on the registered output beat the next cycle.
// Backpressure: output beat holds while o_out_vld & !i_out_rdy; o_in_rdy drops while held or ramping.
module c_enc #(
    parameter int W                     = 16,
    parameter int P_ADMIT_COMPLIMENT_EN = 1
) (
    input  logic   clk,
    input  logic   rst,
    c_enc_if.slave bus
);
    localparam int CW      = $clog2(W);
    localparam bit CMPL_EN = (P_ADMIT_COMPLIMENT_EN != 0);

    generate
        if (W < 2) begin : g_bad_w
            $error("c_enc: W must be >= 2");
        end
    endgenerate

`ifdef C_ENC_RAMP_EN
    typedef enum logic {IDLE, RAMP} state_t;
`else
    typedef enum logic {IDLE} state_t;
`endif

    state_t state;
    logic   out_fire;
    logic   in_acc;
    logic   in_err;
    logic   in_cmpl;

    function automatic logic [W-1:0] thermo(input logic [CW-1:0] n, input logic inv);
        logic [W-1:0] c;
        for (int i = 0; i < W; i++) c[i] = (i < int'(n));
        return inv ? ~c : c;
    endfunction

    assign out_fire     = bus.o_out_vld & bus.i_out_rdy;
    assign bus.o_in_rdy = (state == IDLE) & (!bus.o_out_vld | bus.i_out_rdy);
    assign in_acc       = bus.i_in_vld & bus.o_in_rdy;
    // Only reachable when W is not a power of two.
    assign in_err       = {1'b0, bus.i_in_n} >= (CW+1)'(W);
    assign in_cmpl      = CMPL_EN & bus.i_in_compliment;

`ifdef C_ENC_RAMP_EN
    logic [CW-1:0] k;
    logic [CW-1:0] k_nxt;
    logic [CW-1:0] n_tgt;
    logic          cmpl_q;
    logic          start_ramp;

    assign k_nxt      = k + CW'(1);
    assign start_ramp = bus.i_in_ramp & (bus.i_in_n != '0) & !in_err;
`else
    logic unused_ramp;
    assign unused_ramp = bus.i_in_ramp;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            bus.o_out_vld        <= 1'b0;
            bus.o_out_x          <= '0;
            bus.o_out_compliment <= 1'b0;
            bus.o_out_last       <= 1'b0;
            bus.o_out_err        <= 1'b0;
`ifdef C_ENC_RAMP_EN
            k                    <= '0;
            n_tgt                <= '0;
            cmpl_q               <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_acc) begin
                        bus.o_out_vld <= 1'b1;
                        if (in_err) begin
                            bus.o_out_x          <= '0;
                            bus.o_out_compliment <= 1'b0;
                            bus.o_out_last       <= 1'b1;
                            bus.o_out_err        <= 1'b1;
                        end else begin
                            bus.o_out_compliment <= in_cmpl;
                            bus.o_out_err        <= 1'b0;
`ifdef C_ENC_RAMP_EN
                            // A zero-length ramp is just the single k=0 beat.
                            if (start_ramp) begin
                                bus.o_out_x    <= thermo('0, in_cmpl);
                                bus.o_out_last <= 1'b0;
                                k              <= '0;
                                n_tgt          <= bus.i_in_n;
                                cmpl_q         <= in_cmpl;
                                state          <= RAMP;
                            end else begin
                                bus.o_out_x    <= thermo(bus.i_in_ramp ? '0 : bus.i_in_n, in_cmpl);
                                bus.o_out_last <= 1'b1;
                            end
`else
                            bus.o_out_x    <= thermo(bus.i_in_n, in_cmpl);
                            bus.o_out_last <= 1'b1;
`endif
                        end
                    end else if (out_fire) begin
                        bus.o_out_vld <= 1'b0;
                    end
                end
`ifdef C_ENC_RAMP_EN
                RAMP: begin
                    if (out_fire) begin
                        k              <= k_nxt;
                        bus.o_out_x    <= thermo(k_nxt, cmpl_q);
                        bus.o_out_last <= (k_nxt == n_tgt);
                        if (k_nxt == n_tgt) state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
